// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one outstanding imem request,
// and holds the returned word in a single output register feeding decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic [31:0] id_pc_q, id_pc_d;

    // A new request may only go out when the output slot is free by this edge.
    assign imem_req = !rst && (state_q == S_FETCH) && !redirect
                      && (!id_valid_q || id_ready);
    assign imem_addr = pc_q;

    assign id_valid = id_valid_q;
    assign id_inst  = id_inst_q;
    assign id_pc    = id_pc_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        id_valid_d = id_valid_q;
        id_inst_d  = id_inst_q;
        id_pc_d    = id_pc_q;

        if (id_valid_q && id_ready) begin
            id_valid_d = 1'b0;
            id_inst_d  = NOP_INST;
        end

        if (redirect) begin
            pc_d       = redirect_pc & ~32'h3;
            id_valid_d = 1'b0;
            id_inst_d  = NOP_INST;
            case (state_q)
                S_FETCH: state_d = S_FETCH;
                S_WAIT:  state_d = imem_rvalid ? S_FETCH : S_DRAIN;
                S_DRAIN: state_d = S_DRAIN;
                default: state_d = S_FETCH;
            endcase
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (imem_req) begin
                        req_pc_d = pc_q;
                        pc_d     = pc_q + 32'd4;
                        state_d  = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        id_inst_d  = imem_rdata;
                        id_pc_d    = req_pc_q;
                        id_valid_d = 1'b1;
                        state_d    = S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (imem_rvalid) begin
                        state_d = S_FETCH;
                    end
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            req_pc_q   <= 32'h0;
            id_valid_q <= 1'b0;
            id_inst_q  <= NOP_INST;
            id_pc_q    <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            id_valid_q <= id_valid_d;
            id_inst_q  <= id_inst_d;
            id_pc_q    <= id_pc_d;
        end
    end

endmodule
